// File: rtl/diff_commit_queue.sv
// rtl/diff_commit_queue.sv - difftest commit buffer between MEM_WB retire point and the harness
// Circular record queue with overflow detection, flush and a retired-instruction counter.
module diff_commit_queue #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 8,
  parameter int FILTER_X0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit_valid_i,
  input  logic [ADDR_W-1:0]          commit_pc_i,
  input  logic [REG_AW-1:0]          commit_rd_addr_i,
  input  logic                       commit_wreg_i,
  input  logic [DATA_W-1:0]          commit_wdata_i,
  input  logic                       store_valid_i,
  input  logic [ADDR_W-1:0]          store_addr_i,
  input  logic [DATA_W-1:0]          store_wdata_i,
  input  logic [1:0]                 store_wlen_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDR_W-1:0]          out_pc_o,
  output logic [REG_AW-1:0]          out_rd_addr_o,
  output logic                       out_wreg_o,
  output logic [DATA_W-1:0]          out_wdata_o,
  output logic                       out_store_valid_o,
  output logic [ADDR_W-1:0]          out_store_addr_o,
  output logic [DATA_W-1:0]          out_store_wdata_o,
  output logic [1:0]                 out_store_wlen_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic [63:0]                retired_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [REG_AW-1:0] rd_mem    [DEPTH];
  logic              wreg_mem  [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic              sv_mem    [DEPTH];
  logic [ADDR_W-1:0] saddr_mem [DEPTH];
  logic [DATA_W-1:0] sdata_mem [DEPTH];
  logic [1:0]        swlen_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [63:0]   retired_q, retired_d;

  logic full, empty, push, pop, x0_hit;
  logic              wreg_cap;
  logic [ADDR_W-1:0] saddr_cap;
  logic [DATA_W-1:0] sdata_cap;
  logic [1:0]        swlen_cap;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Flush wins over both handshakes; a push into a full queue is only legal alongside a pop.
  assign pop  = !empty && out_ready_i && !flush_i;
  assign push = commit_valid_i && !flush_i && (!full || pop);

  assign x0_hit    = (FILTER_X0 != 0) && (commit_rd_addr_i == '0);
  assign wreg_cap  = commit_wreg_i && !x0_hit;
  assign saddr_cap = store_valid_i ? store_addr_i  : '0;
  assign sdata_cap = store_valid_i ? store_wdata_i : '0;
  assign swlen_cap = store_valid_i ? store_wlen_i  : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    retired_d  = retired_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PONE_C;
        retired_d = retired_q + 64'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PONE_C;
      end
      if (push && !pop) begin
        count_d = count_q + ONE_C;
      end else if (pop && !push) begin
        count_d = count_q - ONE_C;
      end
      if (commit_valid_i && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      retired_q  <= retired_d;
    end
  end

  // Storage carries no reset; its contents are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= commit_pc_i;
      rd_mem[wr_ptr_q]    <= commit_rd_addr_i;
      wreg_mem[wr_ptr_q]  <= wreg_cap;
      wdata_mem[wr_ptr_q] <= commit_wdata_i;
      sv_mem[wr_ptr_q]    <= store_valid_i;
      saddr_mem[wr_ptr_q] <= saddr_cap;
      sdata_mem[wr_ptr_q] <= sdata_cap;
      swlen_mem[wr_ptr_q] <= swlen_cap;
    end
  end

  always_comb begin
    out_valid_o       = !empty;
    out_pc_o          = '0;
    out_rd_addr_o     = '0;
    out_wreg_o        = 1'b0;
    out_wdata_o       = '0;
    out_store_valid_o = 1'b0;
    out_store_addr_o  = '0;
    out_store_wdata_o = '0;
    out_store_wlen_o  = '0;
    if (!empty) begin
      out_pc_o          = pc_mem[rd_ptr_q];
      out_rd_addr_o     = rd_mem[rd_ptr_q];
      out_wreg_o        = wreg_mem[rd_ptr_q];
      out_wdata_o       = wdata_mem[rd_ptr_q];
      out_store_valid_o = sv_mem[rd_ptr_q];
      out_store_addr_o  = saddr_mem[rd_ptr_q];
      out_store_wdata_o = sdata_mem[rd_ptr_q];
      out_store_wlen_o  = swlen_mem[rd_ptr_q];
    end
  end

  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign overflow_o    = overflow_q;
  assign retired_cnt_o = retired_q;

endmodule
